d_sram_bridge: RTL and testbench

- Data-memory bridge directly downstream of the pipeline datapath's MEM stage.
- Consumes the M-stage access: enable, byte-write strobes, ALU address and write data.
- Converts it into a request/addr_ok/data_ok split-handshake bus transaction and returns read data to the pipeline.
- Stalls the pipeline until the transaction completes, then holds the result until the whole pipeline advances.

---
 rtl/d_sram_bridge_pkg.sv | 25 ++
 rtl/d_sram_bridge_req_decode.sv | 42 ++++
 rtl/d_sram_bridge.sv | 110 +++++++++++
 tb/tb_d_sram_bridge.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/d_sram_bridge_pkg.sv
// Shared definitions for the data-memory bridge: FSM encodings, bus transfer
// sizes and the kseg0/kseg1 address window constants.
package d_sram_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
  localparam logic [31:0] KSEG1_BASE = 32'hA000_0000;
  localparam logic [31:0] PHYS_MASK  = 32'h1FFF_FFFF;

  // True for the unmapped kseg0/kseg1 window 0x8000_0000..0xBFFF_FFFF.
  function automatic logic isKseg(input logic [31:0] addr);
    return (addr[31:29] == KSEG0_BASE[31:29]) || (addr[31:29] == KSEG1_BASE[31:29]);
  endfunction

endpackage

// File: rtl/d_sram_bridge_req_decode.sv
// Combinational request decoder: byte strobes and virtual address in,
// bus direction, transfer size and physical address out.
module req_decode
  import d_sram_bridge_pkg::*;
#(
  parameter logic MAP_KSEG = 1'b1
) (
  input  logic [3:0]  dataWen,
  input  logic [31:0] dataAddr,
  output logic        busWr,
  output logic [1:0]  busSize,
  output logic [31:0] busAddr
);

  logic [1:0]  lowBits;
  logic [31:0] physAddr;

  // Strobe pattern selects transfer size and the byte offset inside the word.
  always_comb begin
    busWr   = (dataWen != 4'b0000);
    busSize = SIZE_W;
    lowBits = 2'd0;
    case (dataWen)
      4'b0001: begin busSize = SIZE_B; lowBits = 2'd0; end
      4'b0010: begin busSize = SIZE_B; lowBits = 2'd1; end
      4'b0100: begin busSize = SIZE_B; lowBits = 2'd2; end
      4'b1000: begin busSize = SIZE_B; lowBits = 2'd3; end
      4'b0011: begin busSize = SIZE_H; lowBits = 2'd0; end
      4'b1100: begin busSize = SIZE_H; lowBits = 2'd2; end
      default: begin busSize = SIZE_W; lowBits = 2'd0; end
    endcase
  end

  // kseg0/kseg1 translate by dropping the segment bits; other addresses pass.
  always_comb begin
    physAddr = dataAddr;
    if (MAP_KSEG && isKseg(dataAddr)) physAddr = dataAddr & PHYS_MASK;
    // Replace the two offset bits with the strobe-derived lane offset.
    busAddr = physAddr ^ {30'd0, physAddr[1:0] ^ lowBits};
  end

endmodule

// File: rtl/d_sram_bridge.sv
// Data-memory bridge: turns the M-stage access into a req/addr_ok/data_ok
// bus transaction, stalls the pipeline until it completes and holds the
// read result until the pipeline advances.
module d_sram_bridge
  import d_sram_bridge_pkg::*;
#(
  parameter logic        MAP_KSEG  = 1'b1,
  parameter logic [31:0] RST_RDATA = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_en,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        longest_stall,
  output logic [31:0] data_rdata,
  output logic        d_stall,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  state_t      state;
  state_t      stateNext;
  logic        captureReq;
  logic        captureRdata;
  logic        decWr;
  logic [1:0]  decSize;
  logic [31:0] decAddr;

  req_decode #(.MAP_KSEG(MAP_KSEG)) uDecode (
    .dataWen (data_wen),
    .dataAddr(data_addr),
    .busWr   (decWr),
    .busSize (decSize),
    .busAddr (decAddr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next state plus capture strobes for request fields and read data.
  always_comb begin
    stateNext    = state;
    captureReq   = 1'b0;
    captureRdata = 1'b0;
    case (state)
      IDLE: begin
        if (data_en) begin
          stateNext  = REQ;
          captureReq = 1'b1;
        end
      end
      REQ: begin
        if (bus_addr_ok) begin
          if (bus_data_ok) begin
            stateNext    = DONE;
            captureRdata = ~bus_wr;
          end else begin
            stateNext = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus_data_ok) begin
          stateNext    = DONE;
          captureRdata = ~bus_wr;
        end
      end
      DONE: begin
        if (!longest_stall) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Request fields are frozen at REQ entry so later cpu-side changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_wr    <= 1'b0;
      bus_size  <= SIZE_B;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
    end else if (captureReq) begin
      bus_wr    <= decWr;
      bus_size  <= decSize;
      bus_addr  <= decAddr;
      bus_wdata <= data_wdata;
    end
  end

  // Read data is latched once per load and held through DONE.
  always_ff @(posedge clk) begin
    if (rst)               data_rdata <= RST_RDATA;
    else if (captureRdata) data_rdata <= bus_rdata;
  end

  assign bus_req = (state == REQ);
  assign d_stall = data_en & (state != DONE);

endmodule

// File: tb/tb_d_sram_bridge.sv
// Randomized self-checking bench for d_sram_bridge with a transaction-level
// reference model of bus fields, stall length and returned read data.
module tb_d_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_en;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        longest_stall;
  logic [31:0] data_rdata;
  logic        d_stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int nChecks = 0;
  int nErrors = 0;
  logic [31:0] expRdata;

  d_sram_bridge #(.MAP_KSEG(1'b1), .RST_RDATA(32'h0)) dut (
    .clk(clk), .rst(rst), .data_en(data_en), .data_wen(data_wen),
    .data_addr(data_addr), .data_wdata(data_wdata), .longest_stall(longest_stall),
    .data_rdata(data_rdata), .d_stall(d_stall), .bus_req(bus_req), .bus_wr(bus_wr),
    .bus_size(bus_size), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: physical byte address for a given strobe pattern and virtual address.
  function automatic logic [31:0] modelAddr(input logic [3:0] wen, input logic [31:0] va);
    logic [31:0] pa;
    int off;
    pa = va;
    if (va >= 32'h8000_0000 && va < 32'hC000_0000) pa = va % 32'h2000_0000;
    case (wen)
      4'b0001: off = 0;
      4'b0010: off = 1;
      4'b0100: off = 2;
      4'b1000: off = 3;
      4'b1100: off = 2;
      default: off = 0;
    endcase
    return pa - (pa % 4) + off;
  endfunction

  function automatic logic [1:0] modelSize(input logic [3:0] wen);
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return 2'd0;
      4'b0011, 4'b1100:                   return 2'd1;
      default:                            return 2'd2;
    endcase
  endfunction

  // Quiet cycle with data_en low and a stray data_ok that must be ignored.
  task automatic idleCycle();
    @(negedge clk);
    data_en     = 1'b0;
    longest_stall = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = $urandom_range(0, 1);
    bus_rdata   = $urandom;
    #1;
    checkVal("idle_stall", {31'd0, d_stall}, 32'd0);
    checkVal("idle_req", {31'd0, bus_req}, 32'd0);
    checkVal("idle_rdata", data_rdata, expRdata);
  endtask

  // One complete access: addrLat cycles before addr_ok, dataLat cycles in WAIT,
  // sameCycle returns data together with addr_ok, holdCyc extra DONE stall cycles.
  task automatic access(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int addrLat, input int dataLat,
                        input bit sameCycle, input int holdCyc);
    int stallCnt = 0;
    int expStall;
    logic [31:0] eAddr = modelAddr(wen, addr);
    logic [31:0] eSize = {30'd0, modelSize(wen)};
    logic [31:0] eWr   = {31'd0, wen != 4'b0000};
    // IDLE cycle: access presented, stall raised combinationally
    @(negedge clk);
    data_en = 1'b1; data_wen = wen; data_addr = addr; data_wdata = wdata;
    longest_stall = 1'b1; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    #1;
    checkVal("first_stall", {31'd0, d_stall}, 32'd1);
    checkVal("first_req", {31'd0, bus_req}, 32'd0);
    if (d_stall) stallCnt++;
    // REQ cycles: cpu-side inputs scrambled, bus fields must hold
    for (int i = 0; i <= addrLat; i++) begin
      @(negedge clk);
      data_addr = $urandom; data_wdata = $urandom; data_wen = 4'($urandom);
      bus_addr_ok = (i == addrLat);
      bus_data_ok = (i == addrLat) && sameCycle;
      bus_rdata   = (i == addrLat && sameCycle) ? rdata : $urandom;
      #1;
      checkVal("req_valid", {31'd0, bus_req}, 32'd1);
      checkVal("req_addr", bus_addr, eAddr);
      checkVal("req_size", {30'd0, bus_size}, eSize);
      checkVal("req_wr", {31'd0, bus_wr}, eWr);
      if (wen != 4'b0000) checkVal("req_wdata", bus_wdata, wdata);
      if (d_stall) stallCnt++;
    end
    // WAIT cycles
    if (!sameCycle) begin
      for (int j = 0; j <= dataLat; j++) begin
        @(negedge clk);
        bus_addr_ok = 1'b0;
        bus_data_ok = (j == dataLat);
        bus_rdata   = (j == dataLat) ? rdata : $urandom;
        #1;
        checkVal("wait_req", {31'd0, bus_req}, 32'd0);
        if (d_stall) stallCnt++;
      end
    end
    if (wen == 4'b0000) expRdata = rdata;
    expStall = 1 + (addrLat + 1) + (sameCycle ? 0 : dataLat + 1);
    // DONE: pipeline may still be held by other sources
    for (int k = 0; k <= holdCyc; k++) begin
      @(negedge clk);
      bus_addr_ok = 1'b0;
      bus_data_ok = $urandom_range(0, 1);
      bus_rdata   = $urandom;
      longest_stall = (k < holdCyc);
      #1;
      checkVal("done_stall", {31'd0, d_stall}, 32'd0);
      checkVal("done_req", {31'd0, bus_req}, 32'd0);
      checkVal("done_rdata", data_rdata, expRdata);
    end
    checkVal("stall_cycles", stallCnt, expStall);
    bus_data_ok = 1'b0;
  endtask

  initial begin
    rst = 1'b1; data_en = 1'b0; data_wen = 4'd0; data_addr = 32'd0; data_wdata = 32'd0;
    longest_stall = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;
    expRdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkVal("rst_req", {31'd0, bus_req}, 32'd0);
    checkVal("rst_stall", {31'd0, d_stall}, 32'd0);
    checkVal("rst_wr", {31'd0, bus_wr}, 32'd0);
    checkVal("rst_size", {30'd0, bus_size}, 32'd0);
    checkVal("rst_addr", bus_addr, 32'd0);
    checkVal("rst_wdata", bus_wdata, 32'd0);
    checkVal("rst_rdata", data_rdata, 32'h0);

    // Word load from kseg1, then byte store into kseg0
    access(4'b0000, 32'hBFC0_0010, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0, 0);
    idleCycle();
    access(4'b0100, 32'h8000_1003, 32'h00AB_0000, 32'h1234_5678, 0, 0, 1'b0, 0);
    idleCycle();
    // Slow addr_ok with changing cpu inputs
    access(4'b1111, 32'h0000_4000, 32'hCAFE_F00D, 32'h0, 4, 1, 1'b0, 0);
    idleCycle();
    // addr_ok and data_ok together
    access(4'b0000, 32'h0000_0104, 32'h0, 32'h5A5A_A5A5, 0, 0, 1'b1, 0);
    idleCycle();
    // Held in DONE, then back-to-back access with no idle gap
    access(4'b0000, 32'hA000_0020, 32'h0, 32'h0BAD_CAFE, 1, 0, 1'b0, 3);
    access(4'b0011, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 0, 2, 1'b0, 0);
    idleCycle();

    // Reset while waiting for data
    @(negedge clk);
    data_en = 1'b1; data_wen = 4'b0000; data_addr = 32'h0000_0800; longest_stall = 1'b1;
    @(negedge clk);
    bus_addr_ok = 1'b1;
    @(negedge clk);
    bus_addr_ok = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; data_en = 1'b0; longest_stall = 1'b0;
    expRdata = 32'h0;
    #1;
    checkVal("rstw_req", {31'd0, bus_req}, 32'd0);
    checkVal("rstw_stall", {31'd0, d_stall}, 32'd0);
    checkVal("rstw_rdata", data_rdata, expRdata);
    @(negedge clk);
    bus_data_ok = 1'b1; bus_rdata = 32'hFFFF_0000;
    @(negedge clk);
    bus_data_ok = 1'b0;
    #1;
    checkVal("stray_rdata", data_rdata, expRdata);
    checkVal("stray_req", {31'd0, bus_req}, 32'd0);

    // Randomized accesses
    for (int n = 0; n < 40; n++) begin
      logic [3:0] wen;
      logic [31:0] addr;
      wen  = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      addr = $urandom;
      access(wen, addr, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) idleCycle();
    end
    idleCycle();

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
